spi_psram_responder: RTL

//   Memory-side responder for the cache backing port (cache_addr/din/wmask/valid -> dout/ready).

---
 rtl/spi_psram_responder.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/spi_psram_responder.sv
// Cache backing-port responder that turns each cache request into SPI mode-0 PSRAM frames
// (0x03 word read, 0x02 word or per-byte write), one request in flight at a time.
module spi_psram_responder #(
  parameter int CLK_DIV        = 1,
  parameter int CS_HIGH_CYCLES = 2,
  parameter int ADDR_BITS      = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cache_addr_i,
  input  logic [31:0] cache_din_i,
  input  logic [3:0]  cache_wmask_i,
  input  logic        cache_valid_i,
  output logic [31:0] cache_dout_o,
  output logic        cache_ready_o,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int FW = 8 + ADDR_BITS + 32;
  localparam int EW = $clog2(2 * FW + 1);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int GW = $clog2(CS_HIGH_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, PLAN, SHIFT, FRAME_END, DONE, GAP} state_t;

  state_t                 state_r;
  logic [ADDR_BITS-1:0]   addr_r;
  logic [31:0]            din_r;
  logic [3:0]             pend_r;
  logic                   is_read_r;
  logic [FW-1:0]          sh_r;
  logic [31:0]            rx_r;
  logic [EW-1:0]          edges_r;
  logic [DW-1:0]          div_r;
  logic [GW-1:0]          gap_r;

  logic [1:0]             idx_s;
  logic [7:0]             byte_s;
  logic [ADDR_BITS-1:0]   addr_word_s;
  logic [FW-1:0]          frame_s;
  logic [EW-1:0]          edges_s;
  logic [3:0]             rest_s;
  logic                   unused_addr_s;

  assign unused_addr_s = ^cache_addr_i[31:ADDR_BITS];

  function automatic logic [1:0] lowest_idx(input logic [3:0] m);
    logic [1:0] idx;
    casez (m)
      4'b???1: idx = 2'd0;
      4'b??10: idx = 2'd1;
      4'b?100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Frame builder: word read, full-word write, or the lowest pending byte of a partial write.
  always_comb begin
    idx_s       = lowest_idx(pend_r);
    byte_s      = din_r[{idx_s, 3'b000} +: 8];
    addr_word_s = {addr_r[ADDR_BITS-1:2], 2'b00};
    frame_s     = '0;
    edges_s     = '0;
    rest_s      = 4'b0000;
    if (is_read_r) begin
      frame_s = {8'h03, addr_word_s, 32'h0000_0000};
      edges_s = EW'(2 * FW);
    end else if (pend_r == 4'b1111) begin
      frame_s = {8'h02, addr_word_s, din_r[7:0], din_r[15:8], din_r[23:16], din_r[31:24]};
      edges_s = EW'(2 * FW);
    end else begin
      frame_s = {8'h02, addr_r[ADDR_BITS-1:2], idx_s, byte_s, 24'h00_0000};
      edges_s = EW'(2 * (ADDR_BITS + 16));
      rest_s  = pend_r & ~(4'b0001 << idx_s);
    end
  end

  // Request FSM and SPI shifter; all pad and cache outputs are registered here.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      addr_r        <= '0;
      din_r         <= 32'h0000_0000;
      pend_r        <= 4'b0000;
      is_read_r     <= 1'b0;
      sh_r          <= '0;
      rx_r          <= 32'h0000_0000;
      edges_r       <= '0;
      div_r         <= '0;
      gap_r         <= '0;
      cache_dout_o  <= 32'h0000_0000;
      cache_ready_o <= 1'b0;
      spi_cs_n      <= 1'b1;
      spi_sclk      <= 1'b0;
      spi_mosi      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cache_ready_o <= 1'b0;
          if (cache_valid_i) begin
            addr_r    <= cache_addr_i[ADDR_BITS-1:0];
            din_r     <= cache_din_i;
            pend_r    <= cache_wmask_i;
            is_read_r <= (cache_wmask_i == 4'b0000);
            state_r   <= PLAN;
          end
        end
        PLAN: begin
          spi_cs_n <= 1'b0;
          spi_sclk <= 1'b0;
          spi_mosi <= frame_s[FW-1];
          sh_r     <= frame_s << 1;
          edges_r  <= edges_s;
          pend_r   <= rest_s;
          div_r    <= '0;
          state_r  <= SHIFT;
        end
        SHIFT: begin
          if (div_r == DW'(CLK_DIV - 1)) begin
            div_r    <= '0;
            spi_sclk <= ~spi_sclk;
            edges_r  <= edges_r - EW'(1);
            if (!spi_sclk) begin
              rx_r <= {rx_r[30:0], spi_miso};
            end else if (edges_r == EW'(1)) begin
              // Last falling edge: park MOSI low while CS is about to rise.
              spi_mosi <= 1'b0;
              state_r  <= FRAME_END;
            end else begin
              spi_mosi <= sh_r[FW-1];
              sh_r     <= sh_r << 1;
            end
          end else begin
            div_r <= div_r + DW'(1);
          end
        end
        FRAME_END: begin
          spi_cs_n <= 1'b1;
          gap_r    <= '0;
          if (pend_r == 4'b0000) begin
            cache_ready_o <= 1'b1;
            if (is_read_r) begin
              cache_dout_o <= {rx_r[7:0], rx_r[15:8], rx_r[23:16], rx_r[31:24]};
            end
            state_r <= DONE;
          end else begin
            state_r <= GAP;
          end
        end
        DONE: begin
          cache_ready_o <= 1'b0;
          state_r       <= GAP;
        end
        GAP: begin
          if (gap_r == GW'(CS_HIGH_CYCLES - 1)) begin
            state_r <= (pend_r != 4'b0000) ? PLAN : IDLE;
          end else begin
            gap_r <= gap_r + GW'(1);
          end
        end
        default: begin
          state_r       <= IDLE;
          cache_ready_o <= 1'b0;
          spi_cs_n      <= 1'b1;
          spi_sclk      <= 1'b0;
          spi_mosi      <= 1'b0;
        end
      endcase
    end
  end

endmodule
